// File: rtl/frac_expand_if.sv
// Handshake bundle for the fraction expander.
// The upstream side drives num_i/den_i and the downstream side drains sixteenths_o/err_o.
// The "slave" modport is the expander's view of the bundle.
// The "master" modport is the view of whoever feeds and drains it.
interface frac_expand_if #(
  parameter int W = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] num_i;
  logic [W-1:0] den_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sixteenths_o;
  logic         err_o;

  modport slave (
    input  in_valid, num_i, den_i, out_ready,
    output in_ready, out_valid, sixteenths_o, err_o
  );

  modport master (
    output in_valid, num_i, den_i, out_ready,
    input  in_ready, out_valid, sixteenths_o, err_o
  );
endinterface

// File: rtl/frac_expand.sv
// frac_expand: re-expands a reduced fraction num/den (den a power of two) to a
// numerator over 2^(W-1). The numerator is shifted left once per cycle until
// the denominator reaches 2^(W-1). Illegal inputs complete immediately with err_o set.
module frac_expand #(
  parameter int W = 5
) (
  input  logic          clk,
  input  logic          rst,
  frac_expand_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TOP = W'(W - 1);

  state_t       state;
  logic [W-1:0] acc;
  logic [W-1:0] cnt;

  logic [W-1:0] den_idx;
  logic [W-1:0] k_calc;
  logic         den_onehot;
  logic         in_err;

  // Decode the incoming denominator: bit position, shift count, and legality.
  always_comb begin
    den_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (bus.den_i[i]) den_idx = W'(i);
    end
    k_calc     = TOP - den_idx;
    den_onehot = (bus.den_i != '0) && ((bus.den_i & (bus.den_i - ONE)) == '0);
    in_err     = !den_onehot || (bus.num_i > bus.den_i);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      acc              <= '0;
      cnt              <= '0;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.sixteenths_o <= '0;
      bus.err_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            bus.err_o    <= in_err;
            if (in_err) begin
              acc              <= '0;
              cnt              <= '0;
              bus.sixteenths_o <= '0;
              bus.out_valid    <= 1'b1;
              state            <= DONE;
            end else if (k_calc == '0) begin
              acc              <= bus.num_i;
              cnt              <= '0;
              bus.sixteenths_o <= bus.num_i;
              bus.out_valid    <= 1'b1;
              state            <= DONE;
            end else begin
              acc   <= bus.num_i;
              cnt   <= k_calc;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc <= acc << 1;
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            bus.sixteenths_o <= acc << 1;
            bus.out_valid    <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frac_expand.sv
// Self-checking bench for frac_expand.
// Checks a table of directed vectors, randomized vectors against an arithmetic
// model, a back-pressure hold sequence, and a reset that aborts a calculation.
module tb_frac_expand;

  localparam int W = 5;
  localparam int TARGET = 1 << (W - 1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  frac_expand_if #(.W(W)) bus ();

  frac_expand #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  // Compare one observed value against its required value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: plain fraction arithmetic on the numerator and denominator.
  task automatic model(input logic [W-1:0] num, input logic [W-1:0] den,
                       output logic [W-1:0] res, output logic err, output int lat);
    int n, d;
    n = int'(num);
    d = int'(den);
    if (d == 0 || $countones(den) != 1 || n > d) begin
      err = 1'b1;
      res = '0;
      lat = 1;
    end else begin
      err = 1'b0;
      res = W'((n * TARGET) / d);
      lat = 1 + $clog2(TARGET / d);
    end
  endtask

  // Offer one fraction while idle and wait for its result.
  // Latency is the number of cycles from the accept edge until out_valid is seen.
  // The transfer then completes, and the task checks that the DUT returns to idle.
  task automatic applyStimulus(input logic [W-1:0] num, input logic [W-1:0] den, input bit earlyReady,
                               output int lat, output logic [W-1:0] res, output logic err);
    @(negedge clk);
    checkOutput("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.num_i     = num;
    bus.den_i     = den;
    bus.in_valid  = 1'b1;
    bus.out_ready = earlyReady;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = -1;
    res = '0;
    err = 1'b0;
    for (int j = 0; j < 3 * W; j++) begin
      if (bus.out_valid) begin
        lat = j + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat < 0) begin
      checkOutput("out_valid_timeout", 32'd0, 32'd1);
    end else begin
      res = bus.sixteenths_o;
      err = bus.err_o;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("out_valid_after_transfer", 32'(bus.out_valid), 32'd0);
    checkOutput("in_ready_after_transfer", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] res;
    logic err;
    logic [W-1:0] eres;
    logic eerr;
    int elat;
    logic [W-1:0] rnum, rden;
    bit sawValid;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.num_i     = '0;
    bus.den_i     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_sixteenths", 32'(bus.sixteenths_o), 32'd0);
    checkOutput("reset_err", 32'(bus.err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table: num, den, result, err, latency
    vecs.push_back('{num: 5'd1,  den: 5'd2,       res: 5'd8,  err: 1'b0, lat: 4});
    vecs.push_back('{num: 5'd3,  den: 5'd16,      res: 5'd3,  err: 1'b0, lat: 1});
    vecs.push_back('{num: 5'd1,  den: 5'd1,       res: 5'd16, err: 1'b0, lat: 5});
    vecs.push_back('{num: 5'd1,  den: 5'b00110,   res: 5'd0,  err: 1'b1, lat: 1});
    vecs.push_back('{num: 5'd1,  den: 5'd0,       res: 5'd0,  err: 1'b1, lat: 1});
    vecs.push_back('{num: 5'd5,  den: 5'd4,       res: 5'd0,  err: 1'b1, lat: 1});
    vecs.push_back('{num: 5'd0,  den: 5'd8,       res: 5'd0,  err: 1'b0, lat: 2});
    vecs.push_back('{num: 5'd2,  den: 5'd4,       res: 5'd8,  err: 1'b0, lat: 3});
    vecs.push_back('{num: 5'd16, den: 5'd16,      res: 5'd16, err: 1'b0, lat: 1});
    vecs.push_back('{num: 5'd17, den: 5'd16,      res: 5'd0,  err: 1'b1, lat: 1});
    vecs.push_back('{num: 5'd3,  den: 5'd20,      res: 5'd0,  err: 1'b1, lat: 1});
    vecs.push_back('{num: 5'd1,  den: 5'd1,       res: 5'd16, err: 1'b0, lat: 5});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].num, vecs[i].den, i[0], lat, res, err);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d_sixteenths", i), 32'(res), 32'(vecs[i].res));
      checkOutput($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
    end

    // Randomized vectors against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) rden = W'($urandom_range(0, (1 << W) - 1));
      else                           rden = W'(1 << $urandom_range(0, W - 1));
      if ($urandom_range(0, 3) == 0) rnum = W'($urandom_range(0, (1 << W) - 1));
      else                           rnum = W'($urandom_range(0, int'(rden)));
      model(rnum, rden, eres, eerr, elat);
      applyStimulus(rnum, rden, 1'($urandom_range(0, 1)), lat, res, err);
      checkOutput($sformatf("rand%0d_latency(%0d/%0d)", i, rnum, rden), 32'(lat), 32'(elat));
      checkOutput($sformatf("rand%0d_sixteenths(%0d/%0d)", i, rnum, rden), 32'(res), 32'(eres));
      checkOutput($sformatf("rand%0d_err(%0d/%0d)", i, rnum, rden), 32'(err), 32'(eerr));
    end

    // Back-pressure: result held while out_ready is low; a second offer is ignored
    @(negedge clk);
    bus.num_i    = 5'd3;
    bus.den_i    = 5'd8;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sawValid = 1'b0;
    for (int j = 0; j < 3 * W && !sawValid; j++) begin
      @(posedge clk);
      #1;
      sawValid = bus.out_valid;
    end
    checkOutput("hold_valid_seen", 32'(sawValid), 32'd1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.num_i    = 5'd1;
      bus.den_i    = 5'd1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold%0d_sixteenths", j), 32'(bus.sixteenths_o), 32'd6);
      checkOutput($sformatf("hold%0d_err", j), 32'(bus.err_o), 32'd0);
      checkOutput($sformatf("hold%0d_out_valid", j), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("hold%0d_in_ready", j), 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("hold_release_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("hold_release_in_ready", 32'(bus.in_ready), 32'd1);
    sawValid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("ignored_offer_no_result", 32'(sawValid), 32'd0);

    // Reset during the second SHIFT cycle aborts the calculation
    @(negedge clk);
    bus.num_i    = 5'd1;
    bus.den_i    = 5'd1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_in_ready_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("abort_sixteenths", 32'(bus.sixteenths_o), 32'd0);
    checkOutput("abort_err", 32'(bus.err_o), 32'd0);
    sawValid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("abort_no_result", 32'(sawValid), 32'd0);
    bus.out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
